// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with one-bubble load-use interlock.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage #(
  parameter int DWIDTH = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DWIDTH-1:0] id_pc,
  input  logic [4:0]        id_rs1_addr,
  input  logic [4:0]        id_rs2_addr,
  input  logic [4:0]        id_rd_addr,
  input  logic [DWIDTH-1:0] id_rs1_data,
  input  logic [DWIDTH-1:0] id_rs2_data,
  input  logic [DWIDTH-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_reg_we,
  input  logic              id_mem_rd,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [DWIDTH-1:0] ex_pc,
  output logic [4:0]        ex_rs1_addr,
  output logic [4:0]        ex_rs2_addr,
  output logic [4:0]        ex_rd_addr,
  output logic [DWIDTH-1:0] ex_rs1_data,
  output logic [DWIDTH-1:0] ex_rs2_data,
  output logic [DWIDTH-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_reg_we,
  output logic              ex_mem_rd
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [31:0]       bubble_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic [DWIDTH-1:0] pc;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [4:0]        rd_addr;
    logic [DWIDTH-1:0] rs1_data;
    logic [DWIDTH-1:0] rs2_data;
    logic [DWIDTH-1:0] imm;
    logic [CTRL_W-1:0] ctrl;
    logic              reg_we;
    logic              mem_rd;
  } id_ex_t;

  id_ex_t ex_q;
  id_ex_t id_d;

  logic rd_nz;
  logic rd_hit;
  logic load_use;
  logic do_bubble;
  logic do_load;

  assign rd_nz  = |ex_q.rd_addr;
  assign rd_hit = (ex_q.rd_addr == id_rs1_addr)
                | (ex_q.rd_addr == id_rs2_addr);

  assign load_use = ex_q.valid & ex_q.mem_rd & rd_nz
                  & id_valid & rd_hit;

  assign id_stall = rst_n & ~flush & (load_use | ex_stall);

  assign do_bubble = flush | (~ex_stall & load_use);
  assign do_load   = ~flush & ~ex_stall & ~load_use;

  // Write-enables are qualified so an invalid slot never writes or loads.
  always_comb begin
    id_d          = ex_q;
    id_d.valid    = id_valid;
    id_d.pc       = id_pc;
    id_d.rs1_addr = id_rs1_addr;
    id_d.rs2_addr = id_rs2_addr;
    id_d.rd_addr  = id_rd_addr;
    id_d.rs1_data = id_rs1_data;
    id_d.rs2_data = id_rs2_data;
    id_d.imm      = id_imm;
    id_d.ctrl     = id_ctrl;
    id_d.reg_we   = id_valid & id_reg_we;
    id_d.mem_rd   = id_valid & id_mem_rd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      unique case (1'b1)
        do_bubble: begin
          ex_q.valid  <= 1'b0;
          ex_q.reg_we <= 1'b0;
          ex_q.mem_rd <= 1'b0;
        end
        do_load: ex_q <= id_d;
        default: ex_q <= ex_q;
      endcase
    end
  end

  assign ex_valid    = ex_q.valid;
  assign ex_pc       = ex_q.pc;
  assign ex_rs1_addr = ex_q.rs1_addr;
  assign ex_rs2_addr = ex_q.rs2_addr;
  assign ex_rd_addr  = ex_q.rd_addr;
  assign ex_rs1_data = ex_q.rs1_data;
  assign ex_rs2_data = ex_q.rs2_data;
  assign ex_imm      = ex_q.imm;
  assign ex_ctrl     = ex_q.ctrl;
  assign ex_reg_we   = ex_q.reg_we;
  assign ex_mem_rd   = ex_q.mem_rd;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic cnt_inc;

  // Only interlock bubbles count; flush bubbles and holds do not.
  assign cnt_inc = ~flush & ~ex_stall & load_use
                 & ~(&bubble_cnt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (cnt_inc) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vectors, a hold/interlock
// sequence and random traffic against a rule-level model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic [4:0]  id_rd_addr;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [31:0] id_imm;
  logic [15:0] id_ctrl;
  logic        id_reg_we;
  logic        id_mem_rd;
  logic        ex_stall;
  logic        flush;
  logic        id_stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rs1_addr;
  logic [4:0]  ex_rs2_addr;
  logic [4:0]  ex_rd_addr;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_imm;
  logic [15:0] ex_ctrl;
  logic        ex_reg_we;
  logic        ex_mem_rd;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_stage #(.DWIDTH(32), .CTRL_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rd_addr(id_rd_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_ctrl(id_ctrl),
    .id_reg_we(id_reg_we), .id_mem_rd(id_mem_rd),
    .ex_stall(ex_stall), .flush(flush),
    .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_rd_addr(ex_rd_addr),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd)
`ifdef ID_EX_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference: the instruction currently sitting in EX
  typedef struct {
    bit          valid;
    bit   [31:0] pc;
    bit   [4:0]  rs1, rs2, rd;
    bit   [31:0] d1, d2, imm;
    bit   [15:0] ctrl;
    bit          we, ld;
  } slot_t;

  slot_t m;
  longint unsigned m_cnt = 0;

  function automatic bit model_load_use();
    return m.valid && m.ld && m.rd != 0 && id_valid &&
           (m.rd == id_rs1_addr || m.rd == id_rs2_addr);
  endfunction

  function automatic bit model_stall();
    return rst_n && !flush && (model_load_use() || ex_stall);
  endfunction

  task automatic model_edge();
    bit lu;
    lu = model_load_use();
    if (!rst_n) begin
      m = '{default: 0};
      m_cnt = 0;
    end else if (flush) begin
      m.valid = 0; m.we = 0; m.ld = 0;
    end else if (ex_stall) begin
      // hold everything
    end else if (lu) begin
      m.valid = 0; m.we = 0; m.ld = 0;
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
    end else begin
      m.valid = id_valid;
      m.pc = id_pc; m.rs1 = id_rs1_addr; m.rs2 = id_rs2_addr;
      m.rd = id_rd_addr; m.d1 = id_rs1_data; m.d2 = id_rs2_data;
      m.imm = id_imm; m.ctrl = id_ctrl;
      m.we = id_valid && id_reg_we;
      m.ld = id_valid && id_mem_rd;
    end
  endtask

  // One cycle: check id_stall before the edge, outputs after it.
  task automatic step();
    #1;
    chk("id_stall(model)", 32'(id_stall), 32'(model_stall()));
    @(posedge clk);
    model_edge();
    #1;
    chk("ex_valid(model)", 32'(ex_valid), 32'(m.valid));
    chk("ex_reg_we(model)", 32'(ex_reg_we), 32'(m.we));
    chk("ex_mem_rd(model)", 32'(ex_mem_rd), 32'(m.ld));
    if (m.valid) begin
      chk("ex_pc(model)", ex_pc, m.pc);
      chk("ex_rs1_addr(model)", 32'(ex_rs1_addr), 32'(m.rs1));
      chk("ex_rs2_addr(model)", 32'(ex_rs2_addr), 32'(m.rs2));
      chk("ex_rd_addr(model)", 32'(ex_rd_addr), 32'(m.rd));
      chk("ex_rs1_data(model)", ex_rs1_data, m.d1);
      chk("ex_rs2_data(model)", ex_rs2_data, m.d2);
      chk("ex_imm(model)", ex_imm, m.imm);
      chk("ex_ctrl(model)", 32'(ex_ctrl), 32'(m.ctrl));
    end
`ifdef ID_EX_BUBBLE_CNT_EN
    chk("bubble_cnt(model)", bubble_cnt, 32'(m_cnt));
`endif
  endtask

  task automatic drive(input bit r, input bit v, input bit [31:0] pc,
                       input bit [4:0] s1, input bit [4:0] s2,
                       input bit [4:0] d, input bit we, input bit ld,
                       input bit st, input bit fl);
    rst_n = r; id_valid = v; id_pc = pc;
    id_rs1_addr = s1; id_rs2_addr = s2; id_rd_addr = d;
    id_rs1_data = pc * 3; id_rs2_data = pc ^ 32'hA5A5_0000;
    id_imm = pc + 7; id_ctrl = pc[15:0] ^ 16'h5A5A;
    id_reg_we = we; id_mem_rd = ld; ex_stall = st; flush = fl;
  endtask

  typedef struct {
    bit        r, v;
    bit [31:0] pc;
    bit [4:0]  s1, s2, d;
    bit        we, ld, st, fl;
    bit        e_stall, e_valid;
    bit [31:0] e_pc;
    bit [4:0]  e_rd;
    bit        e_we, e_ld;
  } vec_t;

  function automatic vec_t mk(
    bit r, bit v, bit [31:0] pc, bit [4:0] s1, bit [4:0] s2,
    bit [4:0] d, bit we, bit ld, bit st, bit fl,
    bit es, bit ev, bit [31:0] epc, bit [4:0] erd,
    bit ewe, bit eld);
    vec_t t;
    t.r = r; t.v = v; t.pc = pc; t.s1 = s1; t.s2 = s2; t.d = d;
    t.we = we; t.ld = ld; t.st = st; t.fl = fl;
    t.e_stall = es; t.e_valid = ev; t.e_pc = epc; t.e_rd = erd;
    t.e_we = ewe; t.e_ld = eld;
    return t;
  endfunction

  vec_t vt[$];

  initial begin
    m = '{default: 0};
    // r v pc s1 s2 rd we ld st fl | stall valid pc rd we ld
    vt.push_back(mk(0,1,'h100,0,0,0,0,0,0,0, 0,0,'h000,0,0,0));
    vt.push_back(mk(0,1,'h100,0,0,0,0,0,0,0, 0,0,'h000,0,0,0));
    vt.push_back(mk(1,1,'h104,1,2,5,1,0,0,0, 0,1,'h104,5,1,0));
    vt.push_back(mk(1,1,'h108,6,7,3,1,1,0,0, 0,1,'h108,3,1,1));
    vt.push_back(mk(1,1,'h10c,3,8,4,1,0,0,0, 1,0,'h108,3,0,0));
    vt.push_back(mk(1,1,'h10c,3,8,4,1,0,0,0, 0,1,'h10c,4,1,0));
    vt.push_back(mk(1,1,'h110,1,2,0,1,1,0,0, 0,1,'h110,0,1,1));
    vt.push_back(mk(1,1,'h114,0,0,9,1,0,0,0, 0,1,'h114,9,1,0));
    vt.push_back(mk(1,1,'h118,0,0,3,1,1,0,0, 0,1,'h118,3,1,1));
    vt.push_back(mk(1,1,'h11c,0,3,4,1,0,0,1, 0,0,'h118,3,0,0));
    vt.push_back(mk(1,1,'h120,3,0,4,1,0,0,0, 0,1,'h120,4,1,0));
    vt.push_back(mk(1,1,'h124,1,1,7,1,1,0,0, 0,1,'h124,7,1,1));
    vt.push_back(mk(1,1,'h128,1,7,2,1,0,0,0, 1,0,'h124,7,0,0));
    vt.push_back(mk(1,1,'h128,1,7,2,1,0,0,0, 0,1,'h128,2,1,0));
    vt.push_back(mk(1,1,'h12c,1,1,8,1,1,0,0, 0,1,'h12c,8,1,1));
    vt.push_back(mk(1,0,'h130,8,8,2,0,0,0,0, 0,0,'h130,2,0,0));

    foreach (vt[i]) begin
      drive(vt[i].r, vt[i].v, vt[i].pc, vt[i].s1, vt[i].s2,
            vt[i].d, vt[i].we, vt[i].ld, vt[i].st, vt[i].fl);
      #1;
      chk($sformatf("v%0d id_stall", i), 32'(id_stall),
          32'(vt[i].e_stall));
      #0;
      step();
      chk($sformatf("v%0d ex_valid", i), 32'(ex_valid),
          32'(vt[i].e_valid));
      chk($sformatf("v%0d ex_pc", i), ex_pc, vt[i].e_pc);
      chk($sformatf("v%0d ex_rd", i), 32'(ex_rd_addr),
          32'(vt[i].e_rd));
      chk($sformatf("v%0d ex_reg_we", i), 32'(ex_reg_we),
          32'(vt[i].e_we));
      chk($sformatf("v%0d ex_mem_rd", i), 32'(ex_mem_rd),
          32'(vt[i].e_ld));
    end
`ifdef ID_EX_BUBBLE_CNT_EN
    chk("table bubble_cnt", bubble_cnt, 32'd2);
`endif

    // Load held by ex_stall while a dependent waits in ID
    drive(1,1,'h200,1,1,5,1,1,0,0);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1,1,'h204,5,9,6,1,0,1,0);
      #1;
      chk("hold id_stall", 32'(id_stall), 32'd1);
      #0;
      step();
      chk("hold ex_pc", ex_pc, 32'h200);
      chk("hold ex_valid", 32'(ex_valid), 32'd1);
      chk("hold ex_mem_rd", 32'(ex_mem_rd), 32'd1);
`ifdef ID_EX_BUBBLE_CNT_EN
      chk("hold bubble_cnt", bubble_cnt, 32'd2);
`endif
    end
    drive(1,1,'h204,5,9,6,1,0,0,0);
    #1;
    chk("release id_stall", 32'(id_stall), 32'd1);
    #0;
    step();
    chk("release bubble", 32'(ex_valid), 32'd0);
`ifdef ID_EX_BUBBLE_CNT_EN
    chk("release bubble_cnt", bubble_cnt, 32'd3);
`endif
    step();
    chk("dependent enters", ex_pc, 32'h204);
    chk("dependent valid", 32'(ex_valid), 32'd1);

    // Random traffic with small register indices for frequent hits
    for (int n = 0; n < 400; n++) begin
      rst_n       = ($urandom_range(0, 49) != 0);
      id_valid    = $urandom_range(0, 3) != 0;
      id_pc       = $urandom;
      id_rs1_addr = 5'($urandom_range(0, 3));
      id_rs2_addr = 5'($urandom_range(0, 3));
      id_rd_addr  = 5'($urandom_range(0, 3));
      id_rs1_data = $urandom;
      id_rs2_data = $urandom;
      id_imm      = $urandom;
      id_ctrl     = 16'($urandom);
      id_reg_we   = 1'($urandom);
      id_mem_rd   = $urandom_range(0, 2) == 0;
      ex_stall    = $urandom_range(0, 4) == 0;
      flush       = $urandom_range(0, 7) == 0;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
